mips_program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the MIPS 32-bit single-cycle wrapper. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and writes them into instruction memory starting at word address 0. It holds the processor in reset until the image has been fully written, then releases it.

---
 rtl/mips_pkg.sv | 17 +
 rtl/loader_word_packer.sv | 36 +++
 rtl/mips_program_loader.sv | 143 ++++++++++++++
 tb/tb_mips_program_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot-time program loader.
package mips_pkg;

   localparam int LOADER_HDR_BYTES = 2;
   localparam int LOADER_PHASE_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_HDR_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_t;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words; word_done
// marks the cycle whose byte completes a word (word is valid that cycle).
module loader_word_packer
   import mips_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clear,
   input  logic                      push,
   input  logic [7:0]                byte_data,
   output logic [LOADER_PHASE_W-1:0] phase,
   output logic [31:0]               word,
   output logic                      word_done
);

   logic [23:0] shift;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift <= '0;
         phase <= '0;
      end else if (clear) begin
         shift <= '0;
         phase <= '0;
      end else if (push) begin
         shift <= {byte_data, shift[23:8]};
         phase <= phase + LOADER_PHASE_W'(1);
      end
   end

   // The fourth byte is taken straight from the input so the write can be
   // registered on the same edge that accepts it.
   assign word      = {byte_data, shift};
   assign word_done = push && (phase == '1);

endmodule

// File: rtl/mips_program_loader.sv
// Boot loader: byte stream -> instruction memory, holds the CPU in reset until done.
// Optional checksum byte after the payload is enabled by defining LOADER_CHECKSUM_EN.
module mips_program_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset_n,
   output logic              busy,
   output logic              done,
   output logic              error,
   output loader_state_t     state
);

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t PAYLOAD_END = ST_CHK;
`else
   localparam loader_state_t PAYLOAD_END = ST_DONE;
`endif

   loader_state_t              state_n;
   logic                       accept;
   logic                       start;
   logic                       pay_push;
   logic [LOADER_PHASE_W-1:0]  phase;
   logic [31:0]                word;
   logic                       word_done;
   logic [7:0]                 hdr_lo;
   logic [15:0]                count;
   logic [15:0]                words_left;
   logic [ADDR_W-1:0]          word_idx;

   assign accept   = byte_valid && byte_ready;
   assign start    = load_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign pay_push = accept && (state == ST_DATA);
   assign count    = {byte_data, hdr_lo};

   loader_word_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (start),
      .push      (pay_push),
      .byte_data (byte_data),
      .phase     (phase),
      .word      (word),
      .word_done (word_done)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         csum <= '0;
      else if (start)
         csum <= '0;
      else if (pay_push)
         csum <= csum ^ byte_data;
   end
`endif

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (load_start) state_n = ST_HDR_LO;
         ST_HDR_LO: if (accept) state_n = ST_HDR_HI;
         ST_HDR_HI: begin
            if (accept) begin
               if ({1'b0, count} > CAPACITY)
                  state_n = ST_ERR;
               else if (count == 16'd0)
                  state_n = PAYLOAD_END;
               else
                  state_n = ST_DATA;
            end
         end
         ST_DATA:   if (word_done && words_left == 16'd1) state_n = PAYLOAD_END;
`ifdef LOADER_CHECKSUM_EN
         ST_CHK:    if (accept) state_n = (byte_data == csum) ? ST_DONE : ST_ERR;
`endif
         ST_DONE,
         ST_ERR:    if (load_start) state_n = ST_HDR_LO;
         default:   state_n = ST_IDLE;
      endcase
   end

   // cpu_reset_n is released only once DONE has already been held for an edge,
   // so the final memory write has retired before the first fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         byte_ready  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         cpu_reset_n <= 1'b0;
      end else begin
         state       <= state_n;
         byte_ready  <= state_n inside {ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CHK};
         busy        <= state_n inside {ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CHK};
         done        <= (state_n == ST_DONE);
         error       <= (state_n == ST_ERR);
         cpu_reset_n <= (state == ST_DONE) && (state_n == ST_DONE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr_lo     <= '0;
         words_left <= '0;
         word_idx   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= word_done;
         if (start)
            word_idx <= '0;
         if (accept && state == ST_HDR_LO)
            hdr_lo <= byte_data;
         if (accept && state == ST_HDR_HI)
            words_left <= count;
         if (word_done) begin
            imem_addr  <= word_idx;
            imem_wdata <= word;
            word_idx   <= word_idx + ADDR_W'(1);
            words_left <= words_left - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed + randomized bench for mips_program_loader with a word-level write model.
module tb_mips_program_loader;
   import mips_pkg::*;

   logic          clk;
   logic          reset_n;
   logic          load_start;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [7:0]    imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset_n;
   logic          busy;
   logic          done;
   logic          error;
   loader_state_t dut_state;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;

   logic [31:0] img[$];
   logic [7:0]  strm[$];
   logic [39:0] exp_q[$];

   mips_program_loader #(.ADDR_W(8)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_start  (load_start),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .cpu_reset_n (cpu_reset_n),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .state       (dut_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the next expected {addr, word}.
   always @(posedge clk) begin
      logic [39:0] e;
      #1;
      if (imem_we === 1'b1) begin
         wr_count++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed=%0h:%08h expected=no write", imem_addr, imem_wdata);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write", {24'h0, imem_addr, imem_wdata}, {24'h0, e});
         end
      end
   end

   // ---------------- reference model ----------------
   // Image words -> wire bytes (count header, LE payload, optional XOR) and expected writes.
   task automatic build(input bit bad_csum);
      int n;
      logic [7:0] b;
      logic [7:0] x;
      n = img.size();
      x = 8'h00;
      strm = {};
      strm.push_back(8'(n));
      strm.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(img[i] >> (8 * k));
            strm.push_back(b);
            x = x ^ b;
         end
         exp_q.push_back({8'(i), img[i]});
      end
`ifdef LOADER_CHECKSUM_EN
      strm.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
      if (bad_csum) x = 8'h00;
`endif
   endtask

   // ---------------- drivers (entered and left at a negedge) ----------------
   task automatic pulse_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int stall);
      int tries;
      repeat (stall) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      tries = 0;
      while (byte_ready !== 1'b1 && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (byte_ready !== 1'b1) chk("ready_timeout", {63'h0, byte_ready}, 64'h1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_range(input int from, input int to, input int smin, input int smax);
      for (int i = from; i < to; i++)
         send(strm[i], $urandom_range(smax, smin));
   endtask

   task automatic check_done(input string tag, input int wr_before, input int n_words);
      chk({tag, "_done"},     {63'h0, done}, 64'h1);
      chk({tag, "_cpu_rst0"}, {63'h0, cpu_reset_n}, 64'h0);
      chk({tag, "_busy"},     {63'h0, busy}, 64'h0);
      @(negedge clk);
      chk({tag, "_cpu_rst1"}, {63'h0, cpu_reset_n}, 64'h1);
      chk({tag, "_ready"},    {63'h0, byte_ready}, 64'h0);
      chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'h0);
      chk({tag, "_wr_count"}, 64'(wr_count - wr_before), 64'(n_words));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {63'h0, byte_ready}, 64'h0);
      chk({tag, "_we"},    {63'h0, imem_we}, 64'h0);
      chk({tag, "_addr"},  64'(imem_addr), 64'h0);
      chk({tag, "_wdata"}, 64'(imem_wdata), 64'h0);
      chk({tag, "_cpu"},   {63'h0, cpu_reset_n}, 64'h0);
      chk({tag, "_busy"},  {63'h0, busy}, 64'h0);
      chk({tag, "_done"},  {63'h0, done}, 64'h0);
      chk({tag, "_err"},   {63'h0, error}, 64'h0);
      chk({tag, "_state"}, 64'(dut_state), 64'(ST_IDLE));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wb;
      int n;
      reset_n    = 1'b0;
      load_start = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Reference image, no stalls.
      img = '{32'h20080013, 32'h2109FFFF};
      build(1'b0);
      wb = wr_count;
      pulse_start();
      chk("t1_busy", {63'h0, busy}, 64'h1);
      send_range(0, strm.size(), 0, 0);
      check_done("t1", wb, 2);

      // Restart from DONE, source toggling valid, load_start mid-DATA ignored.
      build(1'b0);
      wb = wr_count;
      pulse_start();
      chk("t2_cpu_rst_drop", {63'h0, cpu_reset_n}, 64'h0);
      chk("t2_busy", {63'h0, busy}, 64'h1);
      chk("t2_done_clr", {63'h0, done}, 64'h0);
      send_range(0, 5, 1, 1);
      pulse_start();
      chk("t2_mid_busy", {63'h0, busy}, 64'h1);
      send_range(5, strm.size(), 1, 1);
      check_done("t2", wb, 2);

      // Random images with random stalls.
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(6, 1);
         img = {};
         for (int i = 0; i < n; i++) img.push_back($urandom);
         build(1'b0);
         wb = wr_count;
         pulse_start();
         send_range(0, strm.size(), 0, 2);
         check_done("rand", wb, n);
      end

      // Empty image.
      img = {};
      build(1'b0);
      wb = wr_count;
      pulse_start();
      send_range(0, strm.size(), 0, 1);
      check_done("n0", wb, 0);

      // Full capacity: 256 words, addresses 0..255.
      img = {};
      for (int i = 0; i < 256; i++) img.push_back($urandom);
      build(1'b0);
      wb = wr_count;
      pulse_start();
      send_range(0, strm.size(), 0, 0);
      check_done("full", wb, 256);

      // Overflow header 01 01 (N = 257).
      strm = '{8'h01, 8'h01};
      wb = wr_count;
      pulse_start();
      send_range(0, 2, 0, 0);
      chk("ovf_error", {63'h0, error}, 64'h1);
      chk("ovf_ready", {63'h0, byte_ready}, 64'h0);
      chk("ovf_busy",  {63'h0, busy}, 64'h0);
      chk("ovf_cpu",   {63'h0, cpu_reset_n}, 64'h0);
      @(negedge clk);
      chk("ovf_cpu_hold", {63'h0, cpu_reset_n}, 64'h0);
      chk("ovf_no_write", 64'(wr_count - wb), 64'h0);

`ifdef LOADER_CHECKSUM_EN
      img = '{32'hDDCCBBAA};
      build(1'b0);
      wb = wr_count;
      pulse_start();
      send_range(0, strm.size(), 0, 0);
      check_done("csum_ok", wb, 1);

      build(1'b1);
      wb = wr_count;
      pulse_start();
      send_range(0, strm.size(), 0, 0);
      chk("csum_bad_err",  {63'h0, error}, 64'h1);
      chk("csum_bad_done", {63'h0, done}, 64'h0);
      @(negedge clk);
      chk("csum_bad_cpu",  {63'h0, cpu_reset_n}, 64'h0);
      chk("csum_bad_wr",   64'(wr_count - wb), 64'h1);
`endif

      // Reset pulsed after 6 payload bytes, then a fresh load.
      img = '{32'h01020304, 32'h05060708};
      build(1'b0);
      void'(exp_q.pop_back());
      pulse_start();
      send_range(0, 8, 0, 0);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_exp_left", 64'(exp_q.size()), 64'h0);
      @(negedge clk);
      img = '{32'h44332211};
      build(1'b0);
      wb = wr_count;
      pulse_start();
      send_range(0, strm.size(), 0, 0);
      check_done("post_rst", wb, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
